uart_frame_ctrl: RTL

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_ctrl_pkg.sv | 32 +++
 rtl/uart_frame_ctrl_if.sv | 23 ++
 rtl/uart_frame_ctrl_frame_timeout_cnt.sv | 32 +++
 rtl/uart_frame_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_frame_ctrl_pkg.sv
// Shared constants, state encoding and checksum helper for the UART request/response
// frame controller.
package uart_frame_ctrl_pkg;

    localparam logic [7:0] HDR_REQ    = 8'hAA;
    localparam logic [7:0] HDR_RSP    = 8'h55;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CHK = 8'h01;
    localparam logic [7:0] ST_ENG_TO  = 8'h02;
    localparam logic [7:0] ST_BAD_CMD = 8'h03;
    localparam logic [7:0] CMD_MAX    = 8'h03;
    localparam logic [2:0] RSP_BYTES  = 3'd5;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RX_CMD   = 4'd1,
        RX_DHI   = 4'd2,
        RX_DLO   = 4'd3,
        RX_CHK   = 4'd4,
        ENG_REQ  = 4'd5,
        ENG_WAIT = 4'd6,
        TX_SEND  = 4'd7,
        TX_ACK   = 4'd8,
        TX_DONE  = 4'd9
    } state_t;

    function automatic logic [7:0] chk3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// UART byte stream and RRNS engine handshake bundle; master is the frame controller.
interface uart_frame_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        eng_start;
    logic [1:0]  eng_cmd;
    logic [15:0] eng_din;
    logic        eng_done;
    logic [15:0] eng_dout;

    modport master (
        input  rx_data, rx_valid, tx_busy, eng_done, eng_dout,
        output tx_data, tx_start, eng_start, eng_cmd, eng_din
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, eng_done, eng_dout,
        input  tx_data, tx_start, eng_start, eng_cmd, eng_din
    );
endinterface

// File: rtl/uart_frame_ctrl_frame_timeout_cnt.sv
// Reloadable saturating timeout counter: counts enabled cycles since the last clear and
// flags expiry once LIMIT cycles have elapsed.
module frame_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = LIMIT[W-1:0];
    localparam logic [W-1:0] ONE_V   = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Cycle counter, held at LIMIT so expiry stays asserted until the owner reacts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LIMIT_V)) begin
            cnt_r <= cnt_r + ONE_V;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LIMIT_V);
endmodule

// File: rtl/uart_frame_ctrl.sv
// Receives a 5-byte request over UART, runs it through the RRNS engine and returns a
// 5-byte status/result response.
module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned GAP_TIMEOUT = 1_000_000,
    parameter int unsigned ENG_TIMEOUT = 65_535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_frame_ctrl_if.master     bus,
    output logic [15:0]           frame_cnt,
    output logic                  overrun,
    output logic                  busy
);
    state_t      state_r, state_nx;
    logic [7:0]  cmd_r, dhi_r, dlo_r, status_r, tx_data_r, rsp_byte_s;
    logic [15:0] res_r, eng_din_r, frame_cnt_r;
    logic [2:0]  idx_r;
    logic [1:0]  eng_cmd_r;
    logic        seen_busy_r, tx_start_r, eng_start_r, overrun_r, busy_r;
    logic        in_rx_s, in_back_s, chk_ok_s, cmd_ok_s, gap_exp_s, eng_exp_s;
    logic        unused_clk_hz;

    // CLK_HZ is informational here; baud timing lives in the UART itself
    assign unused_clk_hz = (CLK_HZ > 0);

    assign in_rx_s   = state_r inside {RX_CMD, RX_DHI, RX_DLO, RX_CHK};
    assign in_back_s = state_r inside {ENG_REQ, ENG_WAIT, TX_SEND, TX_ACK, TX_DONE};
    assign chk_ok_s  = (bus.rx_data == chk3(cmd_r, dhi_r, dlo_r));
    assign cmd_ok_s  = (cmd_r <= CMD_MAX);

    frame_timeout_cnt #(.LIMIT(GAP_TIMEOUT)) u_gap_cnt (
        .clk(clk), .rst_n(rst_n), .clear(!in_rx_s || bus.rx_valid),
        .enable(in_rx_s), .expired(gap_exp_s)
    );

    frame_timeout_cnt #(.LIMIT(ENG_TIMEOUT)) u_eng_cnt (
        .clk(clk), .rst_n(rst_n), .clear(state_r != ENG_WAIT),
        .enable(state_r == ENG_WAIT), .expired(eng_exp_s)
    );

    // Next-state logic; a received byte always wins over a coincident gap expiry
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:     if (bus.rx_valid && (bus.rx_data == HDR_REQ)) state_nx = RX_CMD;
                      else state_nx = IDLE;
            RX_CMD:   if (bus.rx_valid) state_nx = RX_DHI;
                      else if (gap_exp_s) state_nx = IDLE;
                      else state_nx = RX_CMD;
            RX_DHI:   if (bus.rx_valid) state_nx = RX_DLO;
                      else if (gap_exp_s) state_nx = IDLE;
                      else state_nx = RX_DHI;
            RX_DLO:   if (bus.rx_valid) state_nx = RX_CHK;
                      else if (gap_exp_s) state_nx = IDLE;
                      else state_nx = RX_DLO;
            RX_CHK:   if (bus.rx_valid && chk_ok_s && cmd_ok_s) state_nx = ENG_REQ;
                      else if (bus.rx_valid) state_nx = TX_SEND;
                      else if (gap_exp_s) state_nx = IDLE;
                      else state_nx = RX_CHK;
            ENG_REQ:  state_nx = ENG_WAIT;
            ENG_WAIT: if (bus.eng_done || eng_exp_s) state_nx = TX_SEND;
                      else state_nx = ENG_WAIT;
            TX_SEND:  if (!bus.tx_busy) state_nx = TX_ACK;
                      else state_nx = TX_SEND;
            TX_ACK:   if (seen_busy_r && !bus.tx_busy && (idx_r == RSP_BYTES - 3'd1)) state_nx = TX_DONE;
                      else if (seen_busy_r && !bus.tx_busy) state_nx = TX_SEND;
                      else state_nx = TX_ACK;
            TX_DONE:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Response byte selected by the transmit index
    always_comb begin
        rsp_byte_s = 8'h00;
        case (idx_r)
            3'd0:    rsp_byte_s = HDR_RSP;
            3'd1:    rsp_byte_s = status_r;
            3'd2:    rsp_byte_s = res_r[15:8];
            3'd3:    rsp_byte_s = res_r[7:0];
            3'd4:    rsp_byte_s = chk3(status_r, res_r[15:8], res_r[7:0]);
            default: rsp_byte_s = 8'h00;
        endcase
    end

    // State register, frame latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_r       <= 8'h00;
            dhi_r       <= 8'h00;
            dlo_r       <= 8'h00;
            status_r    <= 8'h00;
            res_r       <= 16'h0000;
            idx_r       <= 3'd0;
            seen_busy_r <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            eng_start_r <= 1'b0;
            eng_cmd_r   <= 2'd0;
            eng_din_r   <= 16'h0000;
            frame_cnt_r <= 16'h0000;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            busy_r      <= (state_nx != IDLE);
            tx_start_r  <= (state_r == TX_SEND) && !bus.tx_busy;
            eng_start_r <= (state_nx == ENG_REQ);
            if (bus.rx_valid && in_back_s) overrun_r <= 1'b1;
            case (state_r)
                RX_CMD: if (bus.rx_valid) cmd_r <= bus.rx_data;
                RX_DHI: if (bus.rx_valid) dhi_r <= bus.rx_data;
                RX_DLO: if (bus.rx_valid) dlo_r <= bus.rx_data;
                RX_CHK: if (bus.rx_valid) begin
                    res_r <= 16'h0000;
                    if (!chk_ok_s) status_r <= ST_BAD_CHK;
                    else if (!cmd_ok_s) status_r <= ST_BAD_CMD;
                    else begin
                        status_r  <= ST_OK;
                        eng_cmd_r <= cmd_r[1:0];
                        eng_din_r <= {dhi_r, dlo_r};
                    end
                end
                ENG_WAIT: if (bus.eng_done) begin
                    status_r <= ST_OK;
                    res_r    <= bus.eng_dout;
                end else if (eng_exp_s) begin
                    status_r <= ST_ENG_TO;
                    res_r    <= 16'h0000;
                end
                TX_SEND: if (!bus.tx_busy) tx_data_r <= rsp_byte_s;
                TX_ACK: if (!seen_busy_r && bus.tx_busy) seen_busy_r <= 1'b1;
                        else if (seen_busy_r && !bus.tx_busy) begin
                            seen_busy_r <= 1'b0;
                            idx_r       <= idx_r + 3'd1;
                        end
                TX_DONE: begin
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                    idx_r       <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_data   = tx_data_r;
    assign bus.tx_start  = tx_start_r;
    assign bus.eng_start = eng_start_r;
    assign bus.eng_cmd   = eng_cmd_r;
    assign bus.eng_din   = eng_din_r;
    assign frame_cnt     = frame_cnt_r;
    assign overrun       = overrun_r;
    assign busy          = busy_r;
endmodule
